// File: rtl/fetch_unit.sv
// Program counter and fetch stage: drives the instruction memory address, captures the
// returned word into the IR and hands it to decode over a valid/ready handshake.
module fetch_unit #(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  pc_out,
    input  logic [INSTR_W-1:0] instr_in,
    output logic [INSTR_W-1:0] ir_out,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               ir_valid,
    input  logic               ir_ready,
    input  logic               jmp,
    input  logic [ADDR_W-1:0]  jmp_addr,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_off,
    input  logic               halt_req,
    output logic               halted
);

    typedef enum logic {RUN, HALT} state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
    logic               ir_valid_q, ir_valid_d;

    logic               redirect;
    logic               transfer;
    logic [ADDR_W-1:0]  target;

    // Branch offsets are two's complement, so a plain modular add handles negative values.
    assign redirect = jmp | br_taken;
    assign transfer = ir_valid_q & ir_ready;
    assign target   = jmp ? jmp_addr : (ir_pc_q + br_off);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;

        case (state_q)
            RUN: begin
                if (halt_req) begin
                    state_d = HALT;
                    if (redirect) begin
                        pc_d       = target;
                        ir_valid_d = 1'b0;
                    end else if (transfer) begin
                        ir_valid_d = 1'b0;
                    end
                end else if (redirect) begin
                    pc_d       = target;
                    ir_valid_d = 1'b0;
                end else if (!ir_valid_q || ir_ready) begin
                    ir_d       = instr_in;
                    ir_pc_d    = pc_q;
                    ir_valid_d = 1'b1;
                    pc_d       = pc_q + 1'b1;
                end
            end
            HALT: begin
                // Only draining the last IR is still allowed; everything else is frozen.
                if (transfer) begin
                    ir_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            pc_q       <= '0;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    assign pc_out   = pc_q;
    assign ir_out   = ir_q;
    assign ir_pc    = ir_pc_q;
    assign ir_valid = ir_valid_q;
    assign halted   = (state_q == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed walk through fetch/stall/redirect/halt/reset followed by
// random traffic, with a reference model feeding a scoreboard queue.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [3:0]  pc_out;
    logic [15:0] instr_in;
    logic [15:0] ir_out;
    logic [3:0]  ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        jmp;
    logic [3:0]  jmp_addr;
    logic        br_taken;
    logic [3:0]  br_off;
    logic        halt_req;
    logic        halted;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int pc;
        int ir;
        int irPc;
        int valid;
        int halted;
    } expT;

    expT expQ[$];

    // Reference model state: what the fetch stage should look like after each edge.
    int mPc, mIr, mIrPc, mValid, mHalted;

    fetch_unit #(.ADDR_W(4), .INSTR_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .pc_out   (pc_out),
        .instr_in (instr_in),
        .ir_out   (ir_out),
        .ir_pc    (ir_pc),
        .ir_valid (ir_valid),
        .ir_ready (ir_ready),
        .jmp      (jmp),
        .jmp_addr (jmp_addr),
        .br_taken (br_taken),
        .br_off   (br_off),
        .halt_req (halt_req),
        .halted   (halted)
    );

    // Memory image: each word holds twice its address.
    assign instr_in = {11'b0, pc_out, 1'b0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkField(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic modelStep(input bit r, input bit rdy, input bit j, input int ja,
                             input bit b, input int off, input bit h);
        int target;
        int signedOff;
        bit redir;
        signedOff = (off >= 8) ? off - 16 : off;
        redir     = j || b;
        target    = j ? ja : ((mIrPc + signedOff + 16) % 16);
        if (r) begin
            mPc = 0; mIr = 0; mIrPc = 0; mValid = 0; mHalted = 0;
        end else if (mHalted != 0) begin
            if (mValid != 0 && rdy) mValid = 0;
        end else if (h) begin
            mHalted = 1;
            if (redir) begin
                mPc = target; mValid = 0;
            end else if (mValid != 0 && rdy) begin
                mValid = 0;
            end
        end else if (redir) begin
            mPc = target; mValid = 0;
        end else if (mValid == 0 || rdy) begin
            mIr    = 2 * mPc;
            mIrPc  = mPc;
            mValid = 1;
            mPc    = (mPc + 1) % 16;
        end
    endtask

    // Drives one cycle of inputs on the falling edge and queues the expected post-edge state.
    task automatic applyStimulus(input bit r, input bit rdy, input bit j, input int ja,
                                 input bit b, input int off, input bit h);
        expT e;
        @(negedge clk);
        rst      = r;
        ir_ready = rdy;
        jmp      = j;
        jmp_addr = 4'(ja);
        br_taken = b;
        br_off   = 4'(off);
        halt_req = h;
        modelStep(r, rdy, j, ja, b, off, h);
        e.pc = mPc; e.ir = mIr; e.irPc = mIrPc; e.valid = mValid; e.halted = mHalted;
        expQ.push_back(e);
    endtask

    // Fixed expectations at hand-picked points of the directed sequence.
    task automatic checkOutput(input string tag, input int pc, input int ir, input int irPc,
                               input int valid, input int hlt);
        @(posedge clk);
        #2;
        checkField({tag, ".pc_out"},   int'(pc_out),   pc);
        checkField({tag, ".ir_out"},   int'(ir_out),   ir);
        checkField({tag, ".ir_pc"},    int'(ir_pc),    irPc);
        checkField({tag, ".ir_valid"}, int'(ir_valid), valid);
        checkField({tag, ".halted"},   int'(halted),   hlt);
    endtask

    initial begin : monitor
        expT e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkField("sb.pc_out",   int'(pc_out),   e.pc);
                checkField("sb.ir_out",   int'(ir_out),   e.ir);
                checkField("sb.ir_pc",    int'(ir_pc),    e.irPc);
                checkField("sb.ir_valid", int'(ir_valid), e.valid);
                checkField("sb.halted",   int'(halted),   e.halted);
            end
        end
    end

    initial begin : stimulus
        rst = 1'b1; ir_ready = 1'b0; jmp = 1'b0; jmp_addr = '0;
        br_taken = 1'b0; br_off = '0; halt_req = 1'b0;
        mPc = 0; mIr = 0; mIrPc = 0; mValid = 0; mHalted = 0;

        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("reset", 0, 0, 0, 0, 0);

        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput("first", 1, 0, 0, 1, 0);
        for (int i = 0; i < 17; i++) applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput("wrap", 2, 2, 1, 1, 0);
        for (int i = 0; i < 2; i++) applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput("preStall", 4, 6, 3, 1, 0);

        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("stall", 4, 6, 3, 1, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput("unstall", 5, 8, 4, 1, 0);

        applyStimulus(0, 0, 1, 12, 0, 0, 0);
        checkOutput("jump", 12, 8, 4, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput("jumpFetch", 13, 24, 12, 1, 0);

        applyStimulus(0, 1, 0, 0, 1, 14, 0);
        checkOutput("branch", 10, 24, 12, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput("branchFetch", 11, 20, 10, 1, 0);
        applyStimulus(0, 1, 1, 9, 1, 14, 0);
        checkOutput("jmpWins", 9, 20, 10, 0, 0);

        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("halt", 11, 20, 10, 1, 1);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checkOutput("haltJmp", 11, 20, 10, 1, 1);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput("haltDrain", 11, 20, 10, 0, 1);
        applyStimulus(0, 1, 0, 0, 1, 3, 1);
        checkOutput("haltIdle", 11, 20, 10, 0, 1);

        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        checkOutput("midReset", 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput("restart", 1, 0, 0, 1, 0);

        $display("[TB] starting random traffic");
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 39) == 0),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 9) == 0),
                          int'($urandom_range(0, 15)),
                          ($urandom_range(0, 9) == 0),
                          int'($urandom_range(0, 15)),
                          ($urandom_range(0, 59) == 0));
        end

        @(posedge clk);
        @(posedge clk);
        checkField("sb.drained", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
